// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: axis phase encoding and default 640x480@60 timing constants.
package vga_timing_pkg;
  typedef enum logic [1:0] {ACTIVE = 2'd0, FRONT = 2'd1, SYNC = 2'd2, BACK = 2'd3} phase_t;
  localparam int H_ACT_D  = 640;
  localparam int H_FP_D   = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D   = 48;
  localparam int V_ACT_D  = 480;
  localparam int V_FP_D   = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D   = 33;
  localparam int CNT_W_D  = 10;
endpackage

// File: rtl/vga_phase_cnt.sv
// vga_phase_cnt: one timing axis, a phase counter driving an ACTIVE/FRONT/SYNC/BACK FSM.
module vga_phase_cnt
  import vga_timing_pkg::*;
#(
  parameter int LEN_ACT  = H_ACT_D,
  parameter int LEN_FP   = H_FP_D,
  parameter int LEN_SYNC = H_SYNC_D,
  parameter int LEN_BP   = H_BP_D,
  parameter int CNT_W    = CNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output phase_t           state,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);
  phase_t state_nx;
  logic [CNT_W-1:0] cnt_nx, len_m1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACTIVE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  always_comb begin
    len_m1   = state == ACTIVE ? CNT_W'(LEN_ACT - 1) :
               state == FRONT  ? CNT_W'(LEN_FP - 1)  :
               state == SYNC   ? CNT_W'(LEN_SYNC - 1) : CNT_W'(LEN_BP - 1);
    last     = cnt == len_m1;
    cnt_nx   = adv ? (last ? '0 : cnt + 1'b1) : cnt;
    state_nx = adv && last ? phase_t'(state + 2'd1) : state;
  end
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA sync/DE/coordinate generator; define VGA_TIMING_IRQ_EN for the vblank interrupt flop.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACT  = H_ACT_D,
  parameter int H_FP   = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP   = H_BP_D,
  parameter int V_ACT  = V_ACT_D,
  parameter int V_FP   = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP   = V_BP_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             irq_ack,
  output logic             hsync_n,
  output logic             vsync_n,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_start,
  output logic             vblank_irq
);
  phase_t h_state, v_state;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_last, v_last, v_adv;
  // a line ends on the last back-porch pixel
  assign v_adv = pix_en && h_state == BACK && h_last;
  vga_phase_cnt #(.LEN_ACT(H_ACT), .LEN_FP(H_FP), .LEN_SYNC(H_SYNC), .LEN_BP(H_BP), .CNT_W(CNT_W)) u_h (
    .clk(clk), .reset(reset), .adv(pix_en), .state(h_state), .cnt(h_cnt), .last(h_last)
  );
  vga_phase_cnt #(.LEN_ACT(V_ACT), .LEN_FP(V_FP), .LEN_SYNC(V_SYNC), .LEN_BP(V_BP), .CNT_W(CNT_W)) u_v (
    .clk(clk), .reset(reset), .adv(v_adv), .state(v_state), .cnt(v_cnt), .last(v_last)
  );
  always_comb begin
    hsync_n     = h_state != SYNC;
    vsync_n     = v_state != SYNC;
    de          = h_state == ACTIVE && v_state == ACTIVE;
    x           = h_state == ACTIVE ? h_cnt : '0;
    y           = v_state == ACTIVE ? v_cnt : '0;
    frame_start = pix_en && de && h_cnt == '0 && v_cnt == '0;
  end
`ifdef VGA_TIMING_IRQ_EN
  logic irq;
  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else if (v_adv && v_state == ACTIVE && v_last) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end
  assign vblank_irq = irq;
`else
  logic unused_irq;
  assign unused_irq = irq_ack ^ v_last;
  assign vblank_irq = 1'b0;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: directed checks on a reduced 15x11 timing (8/2/3/2 pixels, 4/2/2/3 lines, 165-cycle frame).
module tb_vga_timing_ctrl;
  logic clk = 1'b0, reset, pix_en, irq_ack;
  logic hsync_n, vsync_n, de, frame_start, vblank_irq;
  logic [9:0] x, y;
  int n_cmp = 0, n_bad = 0, pos = 0;
`ifdef VGA_TIMING_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  always #5 clk = ~clk;
  vga_timing_ctrl #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACT(4), .V_FP(2), .V_SYNC(2), .V_BP(3), .CNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .irq_ack(irq_ack),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .vblank_irq(vblank_irq)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic goto(input int t, input bit half);
    while (pos < t) begin
      if (half) begin
        pix_en = 1'b0;
        tick;
        check($sformatf("fs_idle@%0d", pos), frame_start, 0);
      end
      pix_en = 1'b1;
      tick;
      pos++;
    end
  endtask
  task automatic expect_at(input int p, input bit half, input int ex, input int ey,
                           input bit ede, input bit ehs, input bit evs, input bit efs);
    goto(p, half);
    check($sformatf("x@%0d", p), x, ex);
    check($sformatf("y@%0d", p), y, ey);
    check($sformatf("de@%0d", p), de, ede);
    check($sformatf("hs@%0d", p), hsync_n, ehs);
    check($sformatf("vs@%0d", p), vsync_n, evs);
    check($sformatf("fs@%0d", p), frame_start, efs);
    if (half) begin
      pix_en = 1'b0;
      tick;
      check($sformatf("x_hold@%0d", p), x, ex);
      check($sformatf("y_hold@%0d", p), y, ey);
      check($sformatf("de_hold@%0d", p), de, ede);
      check($sformatf("hs_hold@%0d", p), hsync_n, ehs);
      check($sformatf("vs_hold@%0d", p), vsync_n, evs);
      check($sformatf("fs_hold@%0d", p), frame_start, 0);
      pix_en = 1'b1;
      #1;
    end
  endtask
  task automatic do_reset;
    reset  = 1'b1;
    pix_en = 1'b1;
    tick;
    reset  = 1'b0;
    pos    = 0;
    #1;
  endtask
  task automatic run(input bit half);
    do_reset;
    check("irq_rst", vblank_irq, 0);
    expect_at(0, half, 0, 0, 1, 1, 1, 1);
    expect_at(7, half, 7, 0, 1, 1, 1, 0);
    expect_at(8, half, 0, 0, 0, 1, 1, 0);
    expect_at(10, half, 0, 0, 0, 0, 1, 0);
    expect_at(12, half, 0, 0, 0, 0, 1, 0);
    expect_at(13, half, 0, 0, 0, 1, 1, 0);
    expect_at(14, half, 0, 0, 0, 1, 1, 0);
    expect_at(15, half, 0, 1, 1, 1, 1, 0);
    expect_at(52, half, 7, 3, 1, 1, 1, 0);
    expect_at(53, half, 0, 3, 0, 1, 1, 0);
    check("irq_pre", vblank_irq, 0);
    if (!half) begin
      goto(59, 1'b0);
      irq_ack = 1'b1;
    end
    expect_at(60, half, 0, 0, 0, 1, 1, 0);
    check("irq_set", vblank_irq, IRQ_ON);
    if (!half) begin
      goto(61, 1'b0);
      check("irq_ack", vblank_irq, 0);
      irq_ack = 1'b0;
    end
    expect_at(89, half, 0, 0, 0, 1, 1, 0);
    expect_at(90, half, 0, 0, 0, 1, 0, 0);
    expect_at(119, half, 0, 0, 0, 1, 0, 0);
    expect_at(120, half, 0, 0, 0, 1, 1, 0);
    if (!half) begin
      expect_at(164, 1'b0, 0, 0, 0, 1, 1, 0);
      expect_at(165, 1'b0, 0, 0, 1, 1, 1, 1);
      expect_at(180, 1'b0, 0, 1, 1, 1, 1, 0);
      check("irq_f2", vblank_irq, 0);
    end else begin
      goto(125, 1'b1);
      check("irq_held", vblank_irq, IRQ_ON);
      reset  = 1'b1;
      pix_en = 1'b0;
      tick;
      reset  = 1'b0;
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_de", de, 1);
      check("rst_hs", hsync_n, 1);
      check("rst_vs", vsync_n, 1);
      check("rst_irq", vblank_irq, 0);
      check("rst_fs_idle", frame_start, 0);
      pix_en = 1'b1;
      #1;
      check("rst_fs", frame_start, 1);
    end
  endtask
  initial begin
    reset   = 1'b1;
    pix_en  = 1'b0;
    irq_ack = 1'b0;
    run(1'b0);
    run(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
